// File: rtl/cmos_cap_pkg.sv
// Shared types and widths for the DVP capture path: FSM states, counter widths
// and the RGB565 pixel layout.
package cmos_cap_pkg;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_VBLANK = 2'd1,
    S_SKIP   = 2'd2,
    S_ACTIVE = 2'd3
  } cap_state_t;

  localparam int PIX_W  = 11;
  localparam int LINE_W = 10;
  localparam int FRM_W  = 16;
  localparam int SKIP_W = 4;

  // Field order of the packed struct fixes the bit positions: R[15:11], G[10:5], B[4:0].
  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  function automatic rgb565_t pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
    rgb565_t p;
    p.r = hi[7:3];
    p.g = {hi[2:0], lo[7:5]};
    p.b = lo[4:0];
    return p;
  endfunction

endpackage

// File: rtl/cmos_capture_if.sv
// Write side of the camera-to-SDRAM FIFO; the capture block is the master.
interface cmos_capture_if;
  import cmos_cap_pkg::*;

  logic    wr_en;
  rgb565_t wr_data;
  logic    fifo_full;

  modport master (output wr_en, output wr_data, input fifo_full);
  modport slave  (input wr_en, input wr_data, output fifo_full);

endinterface

// File: rtl/cmos_byte_pack.sv
// Pairs consecutive href bytes into RGB565 pixels; emits a one-cycle strobe per pair.
module cmos_byte_pack
  import cmos_cap_pkg::*;
(
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       en,
  input  logic       href,
  input  logic [7:0] data,
  output logic       pix_vld,
  output rgb565_t    pix_data,
  output logic       odd_pend
);

  logic       phase;
  logic [7:0] hi_byte;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      phase    <= 1'b0;
      hi_byte  <= 8'h00;
      pix_vld  <= 1'b0;
      pix_data <= '0;
    end else begin
      pix_vld <= 1'b0;
      if (en && href) begin
        phase <= ~phase;
        if (!phase) begin
          hi_byte <= data;
        end else begin
          pix_vld  <= 1'b1;
          pix_data <= pack_rgb565(hi_byte, data);
        end
      end else begin
        phase <= 1'b0;
      end
    end
  end

  // Still high in the cycle href drops if a lone high byte is being thrown away.
  assign odd_pend = phase;

endmodule

// File: rtl/cmos_capture.sv
// DVP capture: frame sync FSM, start-up frame skipping, FIFO write handshake and
// optional geometry statistics (built when CMOS_CAPTURE_STATS_EN is defined).
//   state    | meaning
//   S_SYNC   | after reset, waiting for vsyn high so capture never starts mid-frame
//   S_VBLANK | vertical blanking, waiting for vsyn to fall
//   S_SKIP   | settling frame, all data ignored
//   S_ACTIVE | frame being captured into the FIFO
module cmos_capture
  import cmos_cap_pkg::*;
#(
  parameter int SKIP_FRAMES = 2,
  parameter int EXP_PIX     = 400,
  parameter int EXP_LINES   = 480
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              cmos_vsyn,
  input  logic              cmos_href,
  input  logic [7:0]        cmos_data,
  cmos_capture_if.master    fifo,
  output logic              frame_start,
  output logic              frame_done,
  output logic              capturing,
  output logic              overflow,
  output logic              frame_err,
  output logic [LINE_W-1:0] line_cnt,
  output logic [FRM_W-1:0]  frame_cnt
);

  localparam logic [SKIP_W-1:0] SKIP_LIM = SKIP_W'(SKIP_FRAMES);

  logic              vsyn_r, vsyn_rr, href_r;
  logic [7:0]        data_r;
  logic              vsyn_fall, vsyn_rise, href_eff;
  cap_state_t        state, state_nxt;
  logic [SKIP_W-1:0] skip_cnt, skip_nxt;
  logic              fs_nxt, fd_nxt;
  logic              pix_vld, odd_pend;
  rgb565_t           pix_data;
  logic              wr_vld;
  rgb565_t           wr_q;

  assign vsyn_fall = vsyn_rr & ~vsyn_r;
  assign vsyn_rise = ~vsyn_rr & vsyn_r;
  assign href_eff  = href_r & ~vsyn_r;
  assign capturing = (state == S_ACTIVE);

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    fs_nxt    = 1'b0;
    fd_nxt    = 1'b0;
    case (state)
      S_SYNC: begin
        if (vsyn_r) state_nxt = S_VBLANK;
      end
      S_VBLANK: begin
        if (vsyn_fall) begin
          if (skip_cnt < SKIP_LIM) begin
            skip_nxt  = skip_cnt + 1'b1;
            state_nxt = S_SKIP;
          end else begin
            state_nxt = S_ACTIVE;
            fs_nxt    = 1'b1;
          end
        end
      end
      S_SKIP: begin
        if (vsyn_rise) state_nxt = S_VBLANK;
      end
      S_ACTIVE: begin
        if (vsyn_rise) begin
          state_nxt = S_VBLANK;
          fd_nxt    = 1'b1;
        end
      end
      default: state_nxt = S_SYNC;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      vsyn_r      <= 1'b0;
      vsyn_rr     <= 1'b0;
      href_r      <= 1'b0;
      data_r      <= 8'h00;
      state       <= S_SYNC;
      skip_cnt    <= '0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      wr_vld      <= 1'b0;
      wr_q        <= '0;
      overflow    <= 1'b0;
    end else begin
      vsyn_r      <= cmos_vsyn;
      vsyn_rr     <= vsyn_r;
      href_r      <= cmos_href;
      data_r      <= cmos_data;
      state       <= state_nxt;
      skip_cnt    <= skip_nxt;
      frame_start <= fs_nxt;
      frame_done  <= fd_nxt;
      // Pixels already in the pipe drain even if the frame has just ended.
      wr_vld      <= pix_vld;
      if (pix_vld) wr_q <= pix_data;
      if (fs_nxt) begin
        overflow <= 1'b0;
      end else if (wr_vld && fifo.fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  cmos_byte_pack u_pack (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .en       (capturing),
    .href     (href_eff),
    .data     (data_r),
    .pix_vld  (pix_vld),
    .pix_data (pix_data),
    .odd_pend (odd_pend)
  );

  // A full FIFO drops the pixel outright; there is no retry buffer.
  assign fifo.wr_en   = wr_vld & ~fifo.fifo_full;
  assign fifo.wr_data = wr_q;

`ifdef CMOS_CAPTURE_STATS_EN
  logic             href_prev;
  logic [PIX_W-1:0] pix_cnt, pix_total;
  logic             line_bad;

  // The last pixel of a line is still in pix_vld when the falling edge is seen.
  assign pix_total = pix_cnt + PIX_W'(pix_vld);
  assign line_bad  = (pix_total != PIX_W'(EXP_PIX)) || odd_pend;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      href_prev <= 1'b0;
      pix_cnt   <= '0;
      line_cnt  <= '0;
      frame_cnt <= '0;
      frame_err <= 1'b0;
    end else begin
      href_prev <= href_eff;
      if (fs_nxt) begin
        pix_cnt   <= '0;
        line_cnt  <= '0;
        frame_err <= 1'b0;
      end else if (capturing) begin
        if (href_prev && !href_eff) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + 1'b1;
          if (line_bad) frame_err <= 1'b1;
        end else if (pix_vld) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (fd_nxt && (line_cnt != LINE_W'(EXP_LINES))) frame_err <= 1'b1;
      end
      if (fd_nxt) frame_cnt <= frame_cnt + 1'b1;
    end
  end
`else
  logic stats_unused;
  assign stats_unused = ^{odd_pend, EXP_PIX[0], EXP_LINES[0]};
  assign line_cnt     = '0;
  assign frame_cnt    = '0;
  assign frame_err    = 1'b0;
`endif

endmodule
